lc3_control_fsm: RTL
====================

# lc3_control_fsm

Multicycle control state machine for the 16-bit datapath. It sequences fetch, decode and execute for ten opcodes. It drives the register-file selects, the ALU operation code, the address-adder selects, bus gates and the load enables of PC, MAR, MDR, IR, register file and condition codes. It also runs a ready-based handshake with memory. The ALU's `aluControl` and the register selects are consumed directly from this block.

## Interface
Parameters: none. State encoding is fixed below.

- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `IR` in 16: current instruction register contents.
- `N`, `Z`, `P` in 1 each: condition-code flags.
- `memRdy` in 1: memory has completed the current access.
- `aluControl` out 2: ALU operation select. 00 = pass A, 01 = ADD, 10 = AND, 11 = NOT.
- `SR1`, `SR2`, `DR` out 3 each: register-file read and write selects.
- `ldPC`, `ldIR`, `ldMAR`, `ldMDR`, `ldReg`, `ldCC` out 1 each: register load enables.
- `gatePC`, `gateMDR`, `gateALU`, `gateMARMUX` out 1 each: bus drivers. At most one is high in any cycle.
- `selPC` out 2: PC source select. 00 = PC+1, 01 = address adder.
- `selEAB1` out 1: adder base select. 0 = PC, 1 = SR1 output.
- `selEAB2` out 2: adder offset select. 00 = 0, 01 = sext(IR[5:0]), 10 = sext(IR[8:0]).
- `selMDR` out 1: MDR source select. 0 = memory, 1 = bus.
- `memEN`, `memWE` out 1 each: memory access enable and write enable.
- `state` out 4: current state, for debug.

## Operation
States (encoding in parentheses):
- FETCH0 (0): `gatePC`, `ldMAR`, `ldPC`, `selPC`=00. Goes to FETCH1.
- FETCH1 (1): `memEN`. `ldMDR`=`memRdy`, `selMDR`=0. Holds until `memRdy`=1, then goes to FETCH2.
- FETCH2 (2): `gateMDR`, `ldIR`. Goes to DECODE.
- DECODE (3): no enables asserted. Dispatches on IR[15:12]:
  - 0001, 0101, 1001 go to ALUOP.
  - 0000 goes to BR.
  - 1100 goes to JMP.
  - 1110 goes to LEA.
  - 0010, 0011, 0110, 0111 go to ADDR.
  - Any other opcode goes to FETCH0 and is treated as a NOP.
- ALUOP (4): `gateALU`, `ldReg`, `ldCC`, `DR`=IR[11:9], `SR1`=IR[8:6], `SR2`=IR[2:0]. `aluControl` = 01 for ADD, 10 for AND, 11 for NOT. Goes to FETCH0.
- BR (5): `ldPC` = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), with `selPC`=01, `selEAB1`=0, `selEAB2`=10. Goes to FETCH0.
- JMP (6): `ldPC`, `selPC`=01, `selEAB1`=1, `selEAB2`=00, `SR1`=IR[8:6]. Goes to FETCH0.
- LEA (7): `gateMARMUX`, `ldReg`, `DR`=IR[11:9], `selEAB1`=0, `selEAB2`=10. `ldCC`=0. Goes to FETCH0.
- ADDR (8): `gateMARMUX`, `ldMAR`.
  - LD/ST: `selEAB1`=0, `selEAB2`=10.
  - LDR/STR: `selEAB1`=1, `selEAB2`=01, `SR1`=IR[8:6].
  - Loads go to READ; stores go to WRMDR.
- READ (9): `memEN`. `ldMDR`=`memRdy`, `selMDR`=0. Holds until `memRdy`, then goes to LOADREG.
- LOADREG (10): `gateMDR`, `ldReg`, `ldCC`, `DR`=IR[11:9]. Goes to FETCH0.
- WRMDR (11): `SR1`=IR[11:9], `aluControl`=00, `gateALU`, `selMDR`=1, `ldMDR`. Goes to WRITE.
- WRITE (12): `memEN`, `memWE`. Holds until `memRdy`, then goes to FETCH0.

Output rules:
- Any output not listed for a state is 0.
- Outputs are combinational decodes of `state`, `IR`, NZP and `memRdy`.
- `ldMDR` is asserted only in the cycle `memRdy`=1. Wait cycles never reload MDR.
- State codes 13–15 are unreachable. If entered, the next state is FETCH0 with all outputs 0.

## Timing
- Reset:
  - While `reset`=1, every output is 0 (`state` reads 0), regardless of current state.
  - The first edge with `reset`=1 forces `state` to FETCH0.
  - Reset mid-access (FETCH1, READ or WRITE) drops `memEN` and `memWE` in the same cycle.
- Latency with `memRdy` tied high:
  - ALU, BR, JMP and LEA instructions take 5 cycles.
  - LD, LDR, ST and STR take 7 cycles.
- Each `memRdy`=0 cycle during FETCH1, READ or WRITE adds one cycle.
- Handshake: `memEN` stays high and the address (MAR) stays stable until `memRdy` is sampled high. `memRdy` is ignored outside FETCH1, READ and WRITE.
- `IR` is loaded at the end of FETCH2. DECODE and all later states use the new IR.

## Test plan
- Reset, then IR=0x12BD (ADD R1,R2,#-3), `memRdy`=1 → states 0,1,2,3,4,0. In state 4: `aluControl`=01, `DR`=1, `SR1`=2, and `gateALU`, `ldReg`, `ldCC` high.
- IR=0x973F (NOT R3,R4) → in ALUOP: `aluControl`=11, `DR`=3, `SR1`=4. IR=0x5042 (AND) gives `aluControl`=10.
- IR=0x0405 (BRz):
  - With Z=0: BR has `ldPC`=0.
  - With Z=1: `ldPC`=1, `selPC`=01, `selEAB2`=10.
  - Either way, FETCH0 follows.
- IR=0x2003 (LD R0) with `memRdy` low for 3 cycles in READ → READ lasts 4 cycles with `memEN`=1 throughout. `ldMDR` is high only in the 4th cycle. LOADREG follows with `DR`=0 and `ldCC`=1.
- IR=0x7B82 (STR R5,R6,#2):
  - ADDR: `selEAB1`=1, `selEAB2`=01, `SR1`=6.
  - WRMDR: `SR1`=5, `aluControl`=00, `selMDR`=1.
  - WRITE: `memWE`=1.
  - Assert `reset` in WRITE → `memWE`=0 that cycle and `state`=0 next cycle.
- IR=0xD000 (unused opcode) → DECODE, then FETCH0 with no `ldReg`, `ldPC` or `memWE` pulse.

Source files
------------

// File: rtl/lc3_control_fsm_if.sv
// lc3_control_fsm_if
// Bundles the control-unit side of the LC-3 datapath into one interface.
//   Inputs to the control unit : IR[15:0], N, Z, P, memRdy
//   Outputs from the control unit: aluControl, SR1/SR2/DR selects,
//     ld* load enables, gate* bus drivers, selPC/selEAB1/selEAB2/selMDR,
//     memEN/memWE memory handshake, state (debug)
// Modports:
//   master - the control FSM (drives the control outputs)
//   slave  - the datapath/memory side (drives IR, flags and memRdy)

interface lc3_control_fsm_if;
    logic [15:0] IR;
    logic        N;
    logic        Z;
    logic        P;
    logic        memRdy;

    logic [1:0]  aluControl;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic [2:0]  DR;
    logic        ldPC;
    logic        ldIR;
    logic        ldMAR;
    logic        ldMDR;
    logic        ldReg;
    logic        ldCC;
    logic        gatePC;
    logic        gateMDR;
    logic        gateALU;
    logic        gateMARMUX;
    logic [1:0]  selPC;
    logic        selEAB1;
    logic [1:0]  selEAB2;
    logic        selMDR;
    logic        memEN;
    logic        memWE;
    logic [3:0]  state;

    modport master (
        input  IR, N, Z, P, memRdy,
        output aluControl, SR1, SR2, DR,
        output ldPC, ldIR, ldMAR, ldMDR, ldReg, ldCC,
        output gatePC, gateMDR, gateALU, gateMARMUX,
        output selPC, selEAB1, selEAB2, selMDR,
        output memEN, memWE, state
    );

    modport slave (
        output IR, N, Z, P, memRdy,
        input  aluControl, SR1, SR2, DR,
        input  ldPC, ldIR, ldMAR, ldMDR, ldReg, ldCC,
        input  gatePC, gateMDR, gateALU, gateMARMUX,
        input  selPC, selEAB1, selEAB2, selMDR,
        input  memEN, memWE, state
    );
endinterface

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm
// Multicycle fetch/decode/execute sequencer for the LC-3 datapath.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; also forces every output low while high
//   ctl   - lc3_control_fsm_if.master: IR, NZP flags and memRdy in; register
//           selects, ALU op, load enables, bus gates, mux selects, memory
//           handshake and debug state out
// Outputs are a combinational decode of the current state, IR, NZP and
// memRdy, so ldMDR can follow memRdy in the same cycle and reset can drop
// memEN/memWE immediately.

module lc3_control_fsm (
    input  logic                clk,
    input  logic                reset,
    lc3_control_fsm_if.master   ctl
);

    typedef enum logic [3:0] {
        FETCH0  = 4'd0,
        FETCH1  = 4'd1,
        FETCH2  = 4'd2,
        DECODE  = 4'd3,
        ALUOP   = 4'd4,
        BR      = 4'd5,
        JMP     = 4'd6,
        LEA     = 4'd7,
        ADDR    = 4'd8,
        READ    = 4'd9,
        LOADREG = 4'd10,
        WRMDR   = 4'd11,
        WRITE   = 4'd12
    } stateType;

    stateType currentState;

    // State register and next-state sequencing. Memory states hold until
    // memRdy is seen; codes 13-15 fall into the default and recover to FETCH0.
    always_ff @(posedge clk) begin
        if (reset) begin
            currentState <= FETCH0;
        end else begin
            case (currentState)
                FETCH0:  currentState <= FETCH1;
                FETCH1:  currentState <= ctl.memRdy ? FETCH2 : FETCH1;
                FETCH2:  currentState <= DECODE;
                DECODE: begin
                    case (ctl.IR[15:12])
                        4'b0001, 4'b0101, 4'b1001:          currentState <= ALUOP;
                        4'b0000:                            currentState <= BR;
                        4'b1100:                            currentState <= JMP;
                        4'b1110:                            currentState <= LEA;
                        4'b0010, 4'b0011, 4'b0110, 4'b0111: currentState <= ADDR;
                        default:                            currentState <= FETCH0;
                    endcase
                end
                ALUOP:   currentState <= FETCH0;
                BR:      currentState <= FETCH0;
                JMP:     currentState <= FETCH0;
                LEA:     currentState <= FETCH0;
                // IR[12] is the store bit of LD/ST/LDR/STR.
                ADDR:    currentState <= ctl.IR[12] ? WRMDR : READ;
                READ:    currentState <= ctl.memRdy ? LOADREG : READ;
                LOADREG: currentState <= FETCH0;
                WRMDR:   currentState <= WRITE;
                WRITE:   currentState <= ctl.memRdy ? FETCH0 : WRITE;
                default: currentState <= FETCH0;
            endcase
        end
    end

    // Output decode. Everything defaults low; reset masks all outputs,
    // including the debug state, so a mid-access reset releases memory at once.
    always_comb begin
        ctl.aluControl = 2'b00;
        ctl.SR1        = 3'd0;
        ctl.SR2        = 3'd0;
        ctl.DR         = 3'd0;
        ctl.ldPC       = 1'b0;
        ctl.ldIR       = 1'b0;
        ctl.ldMAR      = 1'b0;
        ctl.ldMDR      = 1'b0;
        ctl.ldReg      = 1'b0;
        ctl.ldCC       = 1'b0;
        ctl.gatePC     = 1'b0;
        ctl.gateMDR    = 1'b0;
        ctl.gateALU    = 1'b0;
        ctl.gateMARMUX = 1'b0;
        ctl.selPC      = 2'b00;
        ctl.selEAB1    = 1'b0;
        ctl.selEAB2    = 2'b00;
        ctl.selMDR     = 1'b0;
        ctl.memEN      = 1'b0;
        ctl.memWE      = 1'b0;
        ctl.state      = 4'd0;

        if (!reset) begin
            ctl.state = currentState;
            case (currentState)
                FETCH0: begin
                    ctl.gatePC = 1'b1;
                    ctl.ldMAR  = 1'b1;
                    ctl.ldPC   = 1'b1;
                end
                FETCH1: begin
                    ctl.memEN = 1'b1;
                    ctl.ldMDR = ctl.memRdy;
                end
                FETCH2: begin
                    ctl.gateMDR = 1'b1;
                    ctl.ldIR    = 1'b1;
                end
                ALUOP: begin
                    ctl.gateALU = 1'b1;
                    ctl.ldReg   = 1'b1;
                    ctl.ldCC    = 1'b1;
                    ctl.DR      = ctl.IR[11:9];
                    ctl.SR1     = ctl.IR[8:6];
                    ctl.SR2     = ctl.IR[2:0];
                    case (ctl.IR[15:12])
                        4'b0001: ctl.aluControl = 2'b01;
                        4'b0101: ctl.aluControl = 2'b10;
                        4'b1001: ctl.aluControl = 2'b11;
                        default: ctl.aluControl = 2'b00;
                    endcase
                end
                BR: begin
                    ctl.ldPC    = (ctl.IR[11] & ctl.N) | (ctl.IR[10] & ctl.Z) |
                                  (ctl.IR[9] & ctl.P);
                    ctl.selPC   = 2'b01;
                    ctl.selEAB2 = 2'b10;
                end
                JMP: begin
                    ctl.ldPC    = 1'b1;
                    ctl.selPC   = 2'b01;
                    ctl.selEAB1 = 1'b1;
                    ctl.SR1     = ctl.IR[8:6];
                end
                LEA: begin
                    ctl.gateMARMUX = 1'b1;
                    ctl.ldReg      = 1'b1;
                    ctl.DR         = ctl.IR[11:9];
                    ctl.selEAB2    = 2'b10;
                end
                ADDR: begin
                    ctl.gateMARMUX = 1'b1;
                    ctl.ldMAR      = 1'b1;
                    // IR[14] separates base+offset6 (LDR/STR) from PC+offset9 (LD/ST).
                    if (ctl.IR[14]) begin
                        ctl.selEAB1 = 1'b1;
                        ctl.selEAB2 = 2'b01;
                        ctl.SR1     = ctl.IR[8:6];
                    end else begin
                        ctl.selEAB2 = 2'b10;
                    end
                end
                READ: begin
                    ctl.memEN = 1'b1;
                    ctl.ldMDR = ctl.memRdy;
                end
                LOADREG: begin
                    ctl.gateMDR = 1'b1;
                    ctl.ldReg   = 1'b1;
                    ctl.ldCC    = 1'b1;
                    ctl.DR      = ctl.IR[11:9];
                end
                WRMDR: begin
                    ctl.SR1     = ctl.IR[11:9];
                    ctl.gateALU = 1'b1;
                    ctl.selMDR  = 1'b1;
                    ctl.ldMDR   = 1'b1;
                end
                WRITE: begin
                    ctl.memEN = 1'b1;
                    ctl.memWE = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
